// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_tx
// Brief    : Serial pattern transmitter. Sends a latched pattern MSB-first on
//            x, repeats it reps+1 times with optional zero-filled gap cycles
//            between repetitions, then pulses done. All outputs are registered.
//            Optional macro SEQ_PATTERN_TX_ABORT_EN adds abort/aborted ports.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  input  logic [CNT_W-1:0] gap,
`ifdef SEQ_PATTERN_TX_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             ready,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] C_PAT_W_LEN = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] C_LEN_ONE   = LEN_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   reps_q, reps_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               x_q, x_d;
  logic               x_valid_q, x_valid_d;
  logic               frame_start_q, frame_start_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  logic [LEN_W-1:0]   w_len_clamped;
  logic [PAT_W-1:0]   w_pat_shift;

  assign w_len_clamped = (len > C_PAT_W_LEN) ? C_PAT_W_LEN : len;

  // Next-state logic; outputs are derived from the next state so that the
  // registered outputs describe the state being entered.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    pat_d     = pat_q;
    reps_d    = reps_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    aborted_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          pat_d   = pattern;
          len_d   = w_len_clamped;
          reps_d  = reps;
          gap_d   = gap;
          idx_d   = w_len_clamped - C_LEN_ONE;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (idx_q == '0) begin
          if (reps_q != '0) begin
            reps_d = reps_q - C_CNT_ONE;
            if (gap_q != '0) begin
              gap_cnt_d = gap_q - C_CNT_ONE;
              state_d   = ST_GAP;
            end else begin
              idx_d = len_q - C_LEN_ONE;
            end
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          idx_d = idx_q - C_LEN_ONE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          idx_d   = len_q - C_LEN_ONE;
          state_d = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - C_CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef SEQ_PATTERN_TX_ABORT_EN
    // Abort only cuts an active transfer short; it never produces done.
    if (abort && ((state_q == ST_SEND) || (state_q == ST_GAP))) begin
      state_d   = ST_IDLE;
      aborted_d = 1'b1;
    end
`endif

    w_pat_shift   = pat_d >> idx_d;
    x_valid_d     = (state_d == ST_SEND);
    x_d           = x_valid_d & w_pat_shift[0];
    frame_start_d = x_valid_d && (idx_d == (len_d - C_LEN_ONE));
    ready_d       = (state_d == ST_IDLE);
    done_d        = (state_d == ST_DONE);
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      len_q         <= '0;
      pat_q         <= '0;
      reps_q        <= '0;
      gap_q         <= '0;
      gap_cnt_q     <= '0;
      x_q           <= 1'b0;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      ready_q       <= 1'b1;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      pat_q         <= pat_d;
      reps_q        <= reps_d;
      gap_q         <= gap_d;
      gap_cnt_q     <= gap_cnt_d;
      x_q           <= x_d;
      x_valid_q     <= x_valid_d;
      frame_start_q <= frame_start_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
    end
  end

  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign frame_start = frame_start_q;
  assign ready       = ready_q;
  assign done        = done_q;
`ifdef SEQ_PATTERN_TX_ABORT_EN
  assign aborted     = aborted_q;
`else
  // Without the abort feature the aborted flop stays at zero and is unused.
  logic w_unused_aborted;
  assign w_unused_aborted = aborted_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_tx
// Brief    : Directed self-checking bench for seq_pattern_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;
  logic [3:0] gap;
  logic       x;
  logic       x_valid;
  logic       frame_start;
  logic       ready;
  logic       done;
`ifdef SEQ_PATTERN_TX_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // One bit per captured cycle; the oldest sample ends up in the highest bit.
  logic [63:0] cap_x, cap_xv, cap_fs, cap_rdy, cap_done, cap_ab;

  seq_pattern_tx #(.PAT_W(8), .LEN_W(4), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pattern     (pattern),
    .len         (len),
    .reps        (reps),
    .gap         (gap),
`ifdef SEQ_PATTERN_TX_ABORT_EN
    .abort       (abort),
    .aborted     (aborted),
`endif
    .x           (x),
    .x_valid     (x_valid),
    .frame_start (frame_start),
    .ready       (ready),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request at the next edge (E); returns at E+1 sample point.
  // Inputs are scrambled after acceptance to prove only latched copies are used.
  task automatic launch(input logic [7:0] p, input logic [3:0] l,
                        input logic [3:0] r, input logic [3:0] g, input bit hold);
    pattern = p; len = l; reps = r; gap = g; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    pattern = 8'($urandom); len = 4'($urandom_range(1, 15));
    reps = 4'($urandom); gap = 4'($urandom);
  endtask

  // Sample n cycles starting with the current one; drop start at drop_at.
  task automatic capture(input int n, input int drop_at);
    cap_x = '0; cap_xv = '0; cap_fs = '0; cap_rdy = '0; cap_done = '0; cap_ab = '0;
    for (int i = 0; i < n; i++) begin
      cap_x    = {cap_x[62:0], x};
      cap_xv   = {cap_xv[62:0], x_valid};
      cap_fs   = {cap_fs[62:0], frame_start};
      cap_rdy  = {cap_rdy[62:0], ready};
      cap_done = {cap_done[62:0], done};
`ifdef SEQ_PATTERN_TX_ABORT_EN
      cap_ab   = {cap_ab[62:0], aborted};
`endif
      if (i == drop_at) start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pattern = '0; len = '0; reps = '0; gap = '0;
`ifdef SEQ_PATTERN_TX_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({x, x_valid, frame_start, ready, done} !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00010", {x, x_valid, frame_start, ready, done});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    launch(8'b0000_0101, 4'd3, 4'd0, 4'd0, 1'b0);
    capture(5, -1);
    n_checks++;
    if (cap_x !== 64'b10100) begin n_fail++; $display("FAIL single_x: got %b expected 10100", cap_x[4:0]); end
    n_checks++;
    if (cap_xv !== 64'b11100) begin n_fail++; $display("FAIL single_xv: got %b expected 11100", cap_xv[4:0]); end
    n_checks++;
    if (cap_fs !== 64'b10000) begin n_fail++; $display("FAIL single_fs: got %b expected 10000", cap_fs[4:0]); end
    n_checks++;
    if (cap_done !== 64'b00010) begin n_fail++; $display("FAIL single_done: got %b expected 00010", cap_done[4:0]); end
    n_checks++;
    if (cap_rdy !== 64'b00001) begin n_fail++; $display("FAIL single_ready: got %b expected 00001", cap_rdy[4:0]); end
  endtask

  task automatic test_repeat();
    logic [2:0] sh;
    int nvalid;
    int hits;
    launch(8'b0000_0101, 4'd3, 4'd1, 4'd0, 1'b0);
    capture(8, -1);
    n_checks++;
    if (cap_x !== 64'b10110100) begin n_fail++; $display("FAIL repeat_x: got %b expected 10110100", cap_x[7:0]); end
    n_checks++;
    if (cap_xv !== 64'b11111100) begin n_fail++; $display("FAIL repeat_xv: got %b expected 11111100", cap_xv[7:0]); end
    n_checks++;
    if (cap_fs !== 64'b10010000) begin n_fail++; $display("FAIL repeat_fs: got %b expected 10010000", cap_fs[7:0]); end
    n_checks++;
    if (cap_done !== 64'b00000010) begin n_fail++; $display("FAIL repeat_done: got %b expected 00000010", cap_done[7:0]); end
    // Overlapping 101 detector model fed only with valid bits.
    sh = '0; nvalid = 0; hits = 0;
    for (int i = 7; i >= 0; i--) begin
      if (cap_xv[i]) begin
        sh = {sh[1:0], cap_x[i]};
        nvalid++;
        if (nvalid >= 3 && sh == 3'b101) hits++;
      end
    end
    n_checks++;
    if (hits != 2) begin n_fail++; $display("FAIL repeat_detector_hits: got %0d expected 2", hits); end
  endtask

  task automatic test_gap();
    launch(8'b0000_0011, 4'd2, 4'd2, 4'd2, 1'b0);
    capture(12, -1);
    n_checks++;
    if (cap_xv !== 64'b110011001100) begin n_fail++; $display("FAIL gap_xv: got %b expected 110011001100", cap_xv[11:0]); end
    n_checks++;
    if (cap_x !== 64'b110011001100) begin n_fail++; $display("FAIL gap_x: got %b expected 110011001100", cap_x[11:0]); end
    n_checks++;
    if (cap_fs !== 64'b100010001000) begin n_fail++; $display("FAIL gap_fs: got %b expected 100010001000", cap_fs[11:0]); end
    n_checks++;
    if (cap_done !== 64'b000000000010) begin n_fail++; $display("FAIL gap_done: got %b expected 000000000010", cap_done[11:0]); end
    n_checks++;
    if (cap_rdy !== 64'b000000000001) begin n_fail++; $display("FAIL gap_ready: got %b expected 000000000001", cap_rdy[11:0]); end
  endtask

  task automatic test_len_zero();
    launch(8'hFF, 4'd0, 4'd0, 4'd0, 1'b0);
    capture(3, -1);
    n_checks++;
    if (cap_rdy !== 64'b111) begin n_fail++; $display("FAIL len0_ready: got %b expected 111", cap_rdy[2:0]); end
    n_checks++;
    if (cap_xv !== 64'b000) begin n_fail++; $display("FAIL len0_xv: got %b expected 000", cap_xv[2:0]); end
  endtask

  task automatic test_clamp();
    launch(8'hA5, 4'd12, 4'd0, 4'd0, 1'b0);
    capture(10, -1);
    n_checks++;
    if (cap_xv !== 64'b1111111100) begin n_fail++; $display("FAIL clamp_xv: got %b expected 1111111100", cap_xv[9:0]); end
    n_checks++;
    if (cap_x !== 64'b1010010100) begin n_fail++; $display("FAIL clamp_x: got %b expected 1010010100", cap_x[9:0]); end
    n_checks++;
    if (cap_done !== 64'b0000000010) begin n_fail++; $display("FAIL clamp_done: got %b expected 0000000010", cap_done[9:0]); end
    n_checks++;
    if (cap_fs !== 64'b1000000000) begin n_fail++; $display("FAIL clamp_fs: got %b expected 1000000000", cap_fs[9:0]); end
  endtask

  task automatic test_back_to_back();
    launch(8'b0000_0101, 4'd3, 4'd0, 4'd0, 1'b1);
    // Restore the request fields so the second acceptance sends the same frame.
    pattern = 8'b0000_0101; len = 4'd3; reps = 4'd0; gap = 4'd0;
    capture(10, 5);
    n_checks++;
    if (cap_rdy !== 64'b0000100001) begin n_fail++; $display("FAIL b2b_ready: got %b expected 0000100001", cap_rdy[9:0]); end
    n_checks++;
    if (cap_xv !== 64'b1110011100) begin n_fail++; $display("FAIL b2b_xv: got %b expected 1110011100", cap_xv[9:0]); end
    n_checks++;
    if (cap_x !== 64'b1010010100) begin n_fail++; $display("FAIL b2b_x: got %b expected 1010010100", cap_x[9:0]); end
    n_checks++;
    if (cap_done !== 64'b0001000010) begin n_fail++; $display("FAIL b2b_done: got %b expected 0001000010", cap_done[9:0]); end
    n_checks++;
    if (cap_fs !== 64'b1000010000) begin n_fail++; $display("FAIL b2b_fs: got %b expected 1000010000", cap_fs[9:0]); end
  endtask

  task automatic test_async_reset();
    launch(8'b0000_0111, 4'd3, 4'd3, 4'd0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if ({x, x_valid} !== 2'b11) begin n_fail++; $display("FAIL areset_pre: got %b expected 11", {x, x_valid}); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({x, x_valid, frame_start, ready, done} !== 5'b00010) begin
      n_fail++;
      $display("FAIL areset_async: got %b expected 00010", {x, x_valid, frame_start, ready, done});
    end
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;
    capture(4, -1);
    n_checks++;
    if (cap_done !== 64'b0000) begin n_fail++; $display("FAIL areset_no_done: got %b expected 0000", cap_done[3:0]); end
    n_checks++;
    if (cap_rdy !== 64'b1111) begin n_fail++; $display("FAIL areset_idle: got %b expected 1111", cap_rdy[3:0]); end
    launch(8'b0000_0101, 4'd3, 4'd0, 4'd0, 1'b0);
    capture(5, -1);
    n_checks++;
    if (cap_x !== 64'b10100) begin n_fail++; $display("FAIL areset_restart_x: got %b expected 10100", cap_x[4:0]); end
    n_checks++;
    if (cap_done !== 64'b00010) begin n_fail++; $display("FAIL areset_restart_done: got %b expected 00010", cap_done[4:0]); end
  endtask

`ifdef SEQ_PATTERN_TX_ABORT_EN
  task automatic test_abort();
    launch(8'b0000_0011, 4'd2, 4'd2, 4'd2, 1'b0);
    cap_xv = '0; cap_rdy = '0; cap_done = '0; cap_ab = '0;
    for (int i = 0; i < 6; i++) begin
      cap_xv   = {cap_xv[62:0], x_valid};
      cap_rdy  = {cap_rdy[62:0], ready};
      cap_done = {cap_done[62:0], done};
      cap_ab   = {cap_ab[62:0], aborted};
      abort = (i == 3);
      @(posedge clk); #1;
    end
    abort = 1'b0;
    n_checks++;
    if (cap_ab !== 64'b000010) begin n_fail++; $display("FAIL abort_pulse: got %b expected 000010", cap_ab[5:0]); end
    n_checks++;
    if (cap_rdy !== 64'b000011) begin n_fail++; $display("FAIL abort_ready: got %b expected 000011", cap_rdy[5:0]); end
    n_checks++;
    if (cap_xv !== 64'b110000) begin n_fail++; $display("FAIL abort_xv: got %b expected 110000", cap_xv[5:0]); end
    n_checks++;
    if (cap_done !== 64'b000000) begin n_fail++; $display("FAIL abort_done: got %b expected 000000", cap_done[5:0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_gap();
    test_len_zero();
    test_clamp();
    test_back_to_back();
    test_async_reset();
`ifdef SEQ_PATTERN_TX_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
